// File: rtl/memory_wram_banked.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : memory_wram_banked
// Description : Banked work RAM with a switchable upper bank (SVBK register),
//               a registered DMA read port and a post-reset clear engine that
//               zeroes every byte before the CPU may use the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_wram_banked #(
    parameter int NUM_BANK_BITS  = 3,
    parameter int BANK_SIZE_BITS = 12,
    parameter int CGB_MODE       = 1
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic [15:0] address_bus,
    inout  wire  [7:0]  data_bus,
    input  logic        nread,
    input  logic        nwrite,
    input  logic        nsel,
    input  logic        nsel_svbk,
    input  logic        dma_req,
    input  logic [15:0] dma_address,
    output logic [7:0]  dma_data,
    output logic        dma_valid,
    output logic        busy
);

    localparam int c_ADDR_W = NUM_BANK_BITS + BANK_SIZE_BITS;
    localparam int c_DEPTH  = 1 << c_ADDR_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [c_ADDR_W-1:0]        r_clr_cnt;
    logic [c_ADDR_W-1:0]        w_clr_cnt_next;
    logic [7:0]                 r_mem [c_DEPTH];
    logic [NUM_BANK_BITS-1:0]   w_svbk;
    logic [7:0]                 w_svbk_rd;
    logic                       w_cpu_wr;
    logic                       w_svbk_wr;
    logic                       w_bus_drive;
    logic                       w_dma_fire;
    logic [c_ADDR_W-1:0]        w_cpu_idx;
    logic [c_ADDR_W-1:0]        w_dma_idx;
    logic                       w_mem_we;
    logic [c_ADDR_W-1:0]        w_mem_widx;
    logic [7:0]                 w_mem_wdata;
    logic [7:0]                 w_bus_rdata;
    logic [7:0]                 r_dma_data;
    logic                       r_dma_valid;
    logic                       w_unused;

    // Physical index: bank 0 below x000-x0FFF, switchable bank above it.
    // A zero SVBK value and DMG mode both select bank 1. Only addr[12:0]
    // is decoded, which makes E000-FDFF echo C000-DDFF.
    function automatic logic [c_ADDR_W-1:0] f_map(
        input logic [15:0]              addr,
        input logic [NUM_BANK_BITS-1:0] svbk
    );
        logic [NUM_BANK_BITS-1:0] bank;
        if (!addr[12]) begin
            bank = '0;
        end else if ((CGB_MODE == 0) || (svbk == '0)) begin
            bank = NUM_BANK_BITS'(1);
        end else begin
            bank = svbk;
        end
        return {bank, addr[BANK_SIZE_BITS-1:0]};
    endfunction

    assign busy        = (r_state == ST_CLEAR);
    // Register select wins over RAM select when both are asserted.
    assign w_cpu_wr    = !nwrite && !nsel && nsel_svbk && !busy;
    assign w_svbk_wr   = !nwrite && !nsel_svbk && !busy;
    assign w_bus_drive = !nread && (!nsel || !nsel_svbk);
    assign w_dma_fire  = dma_req && !busy;
    assign w_cpu_idx   = f_map(address_bus, w_svbk);
    assign w_dma_idx   = f_map(dma_address, w_svbk);
    assign w_unused    = ^{address_bus[15:13], dma_address[15:13]};

    assign dma_data  = r_dma_data;
    assign dma_valid = r_dma_valid;

    // Bank select register; in DMG mode it does not exist and reads as 0xFF.
    generate
        if (CGB_MODE != 0) begin : g_cgb
            logic [NUM_BANK_BITS-1:0] r_svbk;

            // SVBK update; takes effect for accesses after this edge.
            always_ff @(posedge clock) begin
                if (!nreset) begin
                    r_svbk <= '0;
                end else if (w_svbk_wr) begin
                    r_svbk <= data_bus[NUM_BANK_BITS-1:0];
                end
            end

            assign w_svbk = r_svbk;

            // Unused upper bits of the register read back as ones.
            always_comb begin
                w_svbk_rd                    = 8'hFF;
                w_svbk_rd[NUM_BANK_BITS-1:0] = r_svbk;
            end
        end else begin : g_dmg
            assign w_svbk    = '0;
            assign w_svbk_rd = 8'hFF;
        end
    endgenerate

    // Clear-engine state register.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    // Clear-engine next state and the single RAM write port arbitration.
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_mem_we       = w_cpu_wr;
        w_mem_widx     = w_cpu_idx;
        w_mem_wdata    = data_bus;
        case (r_state)
            ST_CLEAR: begin
                w_mem_we       = 1'b1;
                w_mem_widx     = r_clr_cnt;
                w_mem_wdata    = 8'h00;
                w_clr_cnt_next = r_clr_cnt + c_ADDR_W'(1);
                if (r_clr_cnt == '1) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_CLEAR;
            end
        endcase
    end

    // RAM write; a write coinciding with a reset edge is dropped.
    always_ff @(posedge clock) begin
        if (nreset && w_mem_we) begin
            r_mem[w_mem_widx] <= w_mem_wdata;
        end
    end

    // Registered DMA read; sees the pre-write value on a same-edge collision.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_dma_valid <= 1'b0;
            r_dma_data  <= 8'h00;
        end else begin
            r_dma_valid <= w_dma_fire;
            if (w_dma_fire) begin
                r_dma_data <= r_mem[w_dma_idx];
            end
        end
    end

    // CPU read data: register, RAM, or 0xFF while the clear is running.
    always_comb begin
        w_bus_rdata = 8'hFF;
        if (!busy) begin
            if (!nsel_svbk) begin
                w_bus_rdata = w_svbk_rd;
            end else begin
                w_bus_rdata = r_mem[w_cpu_idx];
            end
        end
    end

    assign data_bus = w_bus_drive ? w_bus_rdata : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_memory_wram_banked.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_memory_wram_banked
// Description : Scoreboard bench for memory_wram_banked. Two instances: a
//               CGB-mode part (dut0) and a DMG-mode part (dut1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_wram_banked;

    localparam int OP_NONE = 0;
    localparam int OP_WR   = 1;
    localparam int OP_RD   = 2;
    localparam int OP_SVW  = 3;
    localparam int OP_SVR  = 4;

    typedef struct {
        string      name;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic nreset;

    logic [15:0] a0, da0, a1, da1;
    logic        nread0, nwrite0, nsel0, nsvbk0, dreq0, oe0;
    logic        nread1, nwrite1, nsel1, nsvbk1, dreq1, oe1;
    logic [7:0]  drv0, drv1;
    wire  [7:0]  bus0, bus1;
    wire  [7:0]  ddata0, ddata1;
    wire         dvalid0, dvalid1, busy0, busy1;

    assign bus0 = oe0 ? drv0 : 8'hzz;
    assign bus1 = oe1 ? drv1 : 8'hzz;

    memory_wram_banked #(.NUM_BANK_BITS(3), .BANK_SIZE_BITS(12), .CGB_MODE(1)) u_dut0 (
        .clock(clock), .nreset(nreset), .address_bus(a0), .data_bus(bus0),
        .nread(nread0), .nwrite(nwrite0), .nsel(nsel0), .nsel_svbk(nsvbk0),
        .dma_req(dreq0), .dma_address(da0), .dma_data(ddata0),
        .dma_valid(dvalid0), .busy(busy0)
    );

    memory_wram_banked #(.NUM_BANK_BITS(3), .BANK_SIZE_BITS(12), .CGB_MODE(0)) u_dut1 (
        .clock(clock), .nreset(nreset), .address_bus(a1), .data_bus(bus1),
        .nread(nread1), .nwrite(nwrite1), .nsel(nsel1), .nsel_svbk(nsvbk1),
        .dma_req(dreq1), .dma_address(da1), .dma_data(ddata1),
        .dma_valid(dvalid1), .busy(busy1)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t cq0[$], cq1[$], dq0[$], dq1[$];

    // Reference model: flat byte array per part plus its bank register.
    logic [7:0] mmem [2][32768];
    int         msv  [2];
    bit         mbusy;
    bit         count_en;
    int         busy_cnt;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
        end
    endtask

    task automatic chkint(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Spec address map: bank 0 low, SVBK (0 -> 1) high, DMG always bank 1.
    function automatic int midx(input int d, input logic [15:0] a);
        int bank;
        if ((a & 16'h1000) == 16'h0000) bank = 0;
        else if (d == 1 || msv[d] == 0) bank = 1;
        else bank = msv[d];
        return bank * 4096 + int'(a & 16'h0FFF);
    endfunction

    task automatic idle();
        a0 = 16'h0000; da0 = 16'h0000; drv0 = 8'h00; oe0 = 1'b0;
        nread0 = 1'b1; nwrite0 = 1'b1; nsel0 = 1'b1; nsvbk0 = 1'b1; dreq0 = 1'b0;
        a1 = 16'h0000; da1 = 16'h0000; drv1 = 8'h00; oe1 = 1'b0;
        nread1 = 1'b1; nwrite1 = 1'b1; nsel1 = 1'b1; nsvbk1 = 1'b1; dreq1 = 1'b0;
    endtask

    // One bus cycle on part d: drive, predict, update the model, advance.
    task automatic step(input int d, input int op, input logic [15:0] a,
                        input logic [7:0] wd, input bit dreq,
                        input logic [15:0] da, input string nm,
                        input bit both = 1'b0);
        exp_t       e;
        logic [7:0] x;
        bit         rd, wr, rg, ns;
        rd = (op == OP_RD) || (op == OP_SVR);
        wr = (op == OP_WR) || (op == OP_SVW);
        rg = (op == OP_SVW) || (op == OP_SVR);
        ns = !((op == OP_WR) || (op == OP_RD) || (rg && both));
        if (d == 0) begin
            a0 = a; drv0 = wd; oe0 = wr; nread0 = !rd; nwrite0 = !wr;
            nsel0 = ns; nsvbk0 = !rg; dreq0 = dreq; da0 = da;
        end else begin
            a1 = a; drv1 = wd; oe1 = wr; nread1 = !rd; nwrite1 = !wr;
            nsel1 = ns; nsvbk1 = !rg; dreq1 = dreq; da1 = da;
        end
        if (rd) begin
            if (mbusy) x = 8'hFF;
            else if (rg) x = (d == 1) ? 8'hFF : (8'hF8 | 8'(msv[d]));
            else x = mmem[d][midx(d, a)];
            e.name = nm; e.data = x; e.cyc = 0;
            if (d == 0) cq0.push_back(e); else cq1.push_back(e);
        end
        if (dreq && !mbusy) begin
            e.name = {nm, "_dma"}; e.data = mmem[d][midx(d, da)]; e.cyc = cyc + 1;
            if (d == 0) dq0.push_back(e); else dq1.push_back(e);
        end
        if (!mbusy && nreset) begin
            if (op == OP_WR) mmem[d][midx(d, a)] = wd;
            if (op == OP_SVW && d == 0) msv[d] = int'(wd[2:0]);
        end
        @(posedge clock);
        #1;
        idle();
    endtask

    // Monitor: pops an expectation whenever a part presents output.
    always @(negedge clock) begin
        exp_t e;
        if (!nread0 && (!nsel0 || !nsvbk0)) begin
            if (cq0.size() == 0) chk8("cpu0_unexpected_read", bus0, 8'hxx);
            else begin e = cq0.pop_front(); chk8(e.name, bus0, e.data); end
        end
        if (dvalid0) begin
            if (dq0.size() == 0) chkint("dma0_unexpected_valid", 1, 0);
            else begin
                e = dq0.pop_front();
                chk8(e.name, ddata0, e.data);
                chkint({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
        if (!nread1 && (!nsel1 || !nsvbk1)) begin
            if (cq1.size() == 0) chk8("cpu1_unexpected_read", bus1, 8'hxx);
            else begin e = cq1.pop_front(); chk8(e.name, bus1, e.data); end
        end
        if (dvalid1) begin
            if (dq1.size() == 0) chkint("dma1_unexpected_valid", 1, 0);
            else begin
                e = dq1.pop_front();
                chk8(e.name, ddata1, e.data);
                chkint({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
        if (count_en && busy0) busy_cnt++;
    end

    initial begin
        int n;
        int r, op, t;
        logic [15:0] a, da;
        nreset = 1'b0; idle();
        mbusy = 1'b1; count_en = 1'b0; busy_cnt = 0; msv[0] = 0; msv[1] = 0;
        repeat (3) @(posedge clock);
        #1;
        chkint("reset_busy0", int'(busy0), 1);
        chkint("reset_busy1", int'(busy1), 1);
        chkint("reset_dma_valid", int'(dvalid0), 0);
        chk8("reset_dma_data", ddata0, 8'h00);
        nreset = 1'b1;

        // Early part of the clear, then CPU/DMA activity that must be ignored.
        repeat (95) step(0, OP_NONE, 16'h0, 8'h0, 1'b0, 16'h0, "idle");
        step(0, OP_WR,  16'hC000, 8'h77, 1'b0, 16'h0, "busy_wr");
        step(0, OP_RD,  16'hC000, 8'h00, 1'b0, 16'h0, "busy_rd_ff");
        step(0, OP_SVW, 16'hFF70, 8'h03, 1'b0, 16'h0, "busy_svw");
        step(0, OP_SVR, 16'hFF70, 8'h00, 1'b0, 16'h0, "busy_svr_ff");
        step(0, OP_NONE, 16'h0, 8'h0, 1'b1, 16'hC000, "busy_dma");

        // Reset again around clear cycle 100, with a CPU write in that cycle.
        nreset = 1'b0;
        step(0, OP_WR, 16'hC000, 8'h77, 1'b0, 16'h0, "rst_wr");
        chkint("rst_busy", int'(busy0), 1);
        nreset = 1'b1; busy_cnt = 0; count_en = 1'b1;
        step(0, OP_WR,  16'hC000, 8'h77, 1'b0, 16'h0, "clr_wr");
        step(0, OP_RD,  16'hC001, 8'h00, 1'b0, 16'h0, "clr_rd_ff");
        step(0, OP_SVW, 16'hFF70, 8'h03, 1'b0, 16'h0, "clr_svw");
        step(0, OP_SVR, 16'hFF70, 8'h00, 1'b0, 16'h0, "clr_svr_ff");
        step(0, OP_NONE, 16'h0, 8'h0, 1'b1, 16'hC000, "clr_dma");
        n = 0;
        while (busy0 && n < 40000) begin
            step(0, OP_NONE, 16'h0, 8'h0, 1'b0, 16'h0, "wait");
            n++;
        end
        count_en = 1'b0;
        chkint("busy_cycles", busy_cnt, 32768);
        chkint("busy1_done", int'(busy1), 0);
        mbusy = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32768; i++) mmem[d][i] = 8'h00;
            msv[d] = 0;
        end

        step(0, OP_RD,  16'hC000, 8'h00, 1'b0, 16'h0, "c000_zero_after_clear");
        step(0, OP_SVR, 16'hFF70, 8'h00, 1'b0, 16'h0, "svbk_after_clear");

        // Simultaneous RAM and register select: register access only.
        step(0, OP_WR,  16'hDF70, 8'h11, 1'b0, 16'h0, "df70_wr");
        step(0, OP_SVW, 16'hFF70, 8'h00, 1'b0, 16'h0, "both_sel_wr", 1'b1);
        step(0, OP_RD,  16'hDF70, 8'h00, 1'b0, 16'h0, "both_sel_ram_kept");
        step(0, OP_SVR, 16'hFF70, 8'h00, 1'b0, 16'h0, "both_sel_rd", 1'b1);

        // Bank switching.
        step(0, OP_WR,  16'hD000, 8'h55, 1'b0, 16'h0, "bank_wr55");
        step(0, OP_SVW, 16'hFF70, 8'h03, 1'b0, 16'h0, "svbk3");
        step(0, OP_WR,  16'hD000, 8'hAA, 1'b0, 16'h0, "bank_wrAA");
        step(0, OP_SVW, 16'hFF70, 8'h01, 1'b0, 16'h0, "svbk1");
        step(0, OP_RD,  16'hD000, 8'h00, 1'b0, 16'h0, "bank1_rd55");
        step(0, OP_SVW, 16'hFF70, 8'h03, 1'b0, 16'h0, "svbk3b");
        step(0, OP_RD,  16'hD000, 8'h00, 1'b0, 16'h0, "bank3_rdAA");
        step(0, OP_SVR, 16'hFF70, 8'h00, 1'b0, 16'h0, "svbk_rd_fb");
        // Same-cycle svbk write: the DMA read still uses the old bank.
        step(0, OP_SVW, 16'hFF70, 8'h05, 1'b1, 16'hD000, "svbk_old_bank");
        step(0, OP_NONE, 16'h0, 8'h0, 1'b1, 16'hD000, "svbk_new_bank");
        step(0, OP_SVW, 16'hFF70, 8'h00, 1'b0, 16'h0, "svbk0");

        // Echo region.
        step(0, OP_WR, 16'hC123, 8'h12, 1'b0, 16'h0, "echo_wr12");
        step(0, OP_RD, 16'hE123, 8'h00, 1'b0, 16'h0, "echo_rd_e123");
        step(0, OP_WR, 16'hE124, 8'h34, 1'b0, 16'h0, "echo_wr34");
        step(0, OP_RD, 16'hC124, 8'h00, 1'b0, 16'h0, "echo_rd_c124");

        // Back-to-back DMA with a same-edge CPU write collision.
        for (int i = 0; i < 4; i++)
            step(0, OP_WR, 16'hC000 + 16'(i), 8'(i + 1), 1'b0, 16'h0, "dma_preload");
        step(0, OP_NONE, 16'h0,    8'h00, 1'b1, 16'hC000, "dma0");
        step(0, OP_WR,   16'hC001, 8'h99, 1'b1, 16'hC001, "dma1");
        step(0, OP_NONE, 16'h0,    8'h00, 1'b1, 16'hC002, "dma2");
        step(0, OP_NONE, 16'h0,    8'h00, 1'b1, 16'hC003, "dma3");
        step(0, OP_NONE, 16'h0,    8'h00, 1'b0, 16'h0,    "dma_gap");
        step(0, OP_RD,   16'hC001, 8'h00, 1'b0, 16'h0,    "rd_c001_99");

        // DMG part: SVBK writes ignored, register reads 0xFF, bank 1 fixed.
        step(1, OP_SVW, 16'hFF70, 8'h05, 1'b0, 16'h0, "dmg_svw5");
        step(1, OP_WR,  16'hD000, 8'h66, 1'b0, 16'h0, "dmg_wr66");
        step(1, OP_SVR, 16'hFF70, 8'h00, 1'b0, 16'h0, "dmg_svr_ff");
        step(1, OP_RD,  16'hD000, 8'h00, 1'b0, 16'h0, "dmg_rd_d000");
        step(1, OP_RD,  16'hC000, 8'h00, 1'b0, 16'h0, "dmg_rd_c000");
        step(1, OP_NONE, 16'h0, 8'h00, 1'b1, 16'hF000, "dmg_dma_echo");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            r  = int'($urandom_range(0, 99));
            op = (r < 35) ? OP_WR : (r < 65) ? OP_RD : (r < 72) ? OP_SVW :
                 (r < 80) ? OP_SVR : OP_NONE;
            t  = 'hC000 + int'($urandom_range(0, 3)) * 'h1000 + int'($urandom_range(0, 15));
            a  = (op == OP_SVW || op == OP_SVR) ? 16'hFF70 : t[15:0];
            t  = 'hC000 + int'($urandom_range(0, 3)) * 'h1000 + int'($urandom_range(0, 15));
            da = ($urandom_range(0, 3) == 0) ? a : t[15:0];
            step(0, op, a, 8'($urandom), ($urandom_range(0, 2) == 0), da,
                 $sformatf("rnd%0d", i), 1'($urandom_range(0, 1)));
        end

        repeat (3) step(0, OP_NONE, 16'h0, 8'h0, 1'b0, 16'h0, "drain");
        chkint("cpu0_queue_drained", cq0.size(), 0);
        chkint("dma0_queue_drained", dq0.size(), 0);
        chkint("cpu1_queue_drained", cq1.size(), 0);
        chkint("dma1_queue_drained", dq1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
